dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter for the single-ported 128-word data memory. Shares the memory between the core's load/store port (`core_*`) and a debug/loader port (`dbg_*`) that preloads programs and inspects memory. Each access is a registered request/grant/response handshake. Only one memory access is in flight at a time.

## Interface
Parameters:
- `DATA_W`, 32: data word width.
- `ADDR_W`, 7: memory word-address width (128 words).

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `core_req` in 1: core request. Hold it high, with fields stable, until `core_gnt`.
- `core_we` in 1: 1 = write, 0 = read.
- `core_addr` in 32: byte address. Word index is `core_addr[ADDR_W+1:2]`; bits [1:0] and the upper bits are ignored.
- `core_wdata` in `DATA_W`: write data.
- `core_gnt` out 1: one-cycle pulse; the request was accepted and issued to memory.
- `core_rvalid` out 1: one-cycle pulse; the access is complete.
- `core_rdata` out `DATA_W`: read data, valid only while `core_rvalid` is high.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same as the core port, for the debug/loader requester.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable, qualified by `mem_en`.
- `mem_addr` out `ADDR_W`: memory word address.
- `mem_wdata` out `DATA_W`: memory write data.
- `mem_rdata` in `DATA_W`: synchronous read data, valid the cycle after `mem_en`.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
State machine, states IDLE, ACCESS and RESP:
- **IDLE**: if any request is high, register the winner's we/addr/wdata and go to ACCESS. Otherwise stay in IDLE.
- **ACCESS**: drive `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` from the registered values. Pulse the winner's `gnt`. Always go to RESP.
- **RESP**: pulse the winner's `rvalid`.
  - Read: `rdata` = `mem_rdata`.
  - Write: `rdata` = 0.
  - A request high in RESP is a new request, including one from the port just served. Arbitrate it and go directly to ACCESS; if there is none, go to IDLE.

Arbitration happens in IDLE and RESP only. Requests raised during ACCESS wait until RESP.

Tie-break, when both requests are high:
- Round-robin: the port not recorded in `last_winner` wins.
- `last_winner` updates on every arbitration.

Non-winning `gnt`, `rvalid` and `rdata` outputs are 0. A requester must not drop `req` before its `gnt`; if it does, the behaviour is undefined and the bench does not test it.

## Timing
- Reset values: all outputs 0, state IDLE, `last_winner` = DBG, so the core wins the first tie.
- Latency from IDLE: `req` high in cycle 0 → `gnt` and `mem_en` in cycle 1 → `rvalid` in cycle 2.
- Throughput: one access every 2 cycles with back-to-back requests.
- Reset asserted mid-access: all outputs go to 0 asynchronously, including `mem_en`. The in-flight access is dropped, with no `gnt` or `rvalid` delivered. Requesters re-issue after reset.
- Simultaneous requests: exactly one `gnt` per ACCESS; the loser is served in the next ACCESS (cycle +2).
- Write followed by read to the same address: the read returns the new data, because accesses are strictly serialized.
- Address wrap: byte address `0x200` maps to word 0.

## Configuration
Macro `DMEM_ARB_RR_EN`:
- **Defined**: round-robin tie-break as described in Operation.
- **Undefined**: fixed priority, the core always wins a tie. `last_winner` is not implemented. The debug port can starve while the core issues continuous requests.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum (IDLE, ACCESS, RESP);
  - port index constants `PORT_CORE` = 0 and `PORT_DBG` = 1;
  - default widths.
- Sub-module `rr_pick2`: combinational two-way pick that takes the `req` pair and `last_winner` and returns the winner index. When `DMEM_ARB_RR_EN` is undefined it becomes fixed-priority.

## Test plan
- **Single read**: after reset, core reads `addr` `0x14` with memory preloaded to word[i] = i → `core_gnt` in cycle 1 with `mem_addr` = 5; `core_rvalid` in cycle 2 with `core_rdata` = 5.
- **Write then read**: dbg writes `0xE3B39000` to byte `0x40`, then reads it back → `mem_we` = 1 and `mem_addr` = 16 in the first ACCESS; the read returns `0xE3B39000`.
- **Simultaneous requests**: both ports request continuously for 4 accesses.
  - With the macro: grants go core, dbg, core, dbg.
  - Without it: core receives all 4 grants.
- **Back-to-back**: core holds `req` high with 3 different addresses → grants at cycles 1, 3 and 5; `rvalid` at cycles 2, 4 and 6; `busy` stays high throughout.
- **Reset mid-access**: drop `rst` during ACCESS of a write → `mem_en` goes to 0 immediately; no `rvalid`; after release, state is IDLE and the target word is unchanged.
- **Address wrap**: read byte `0x204` → `mem_addr` = 1.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 7;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way requester pick; round-robin when DMEM_ARB_RR_EN is defined, else core-first fixed priority.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
`ifdef DMEM_ARB_RR_EN
    input  logic       last_winner,
`endif
    output logic       winner
);

    always_comb begin
`ifdef DMEM_ARB_RR_EN
        if (req[PORT_CORE] && req[PORT_DBG]) begin
            winner = ~last_winner;
        end else begin
            winner = req[PORT_DBG] ? PORT_DBG : PORT_CORE;
        end
`else
        winner = req[PORT_CORE] ? PORT_CORE : PORT_DBG;
`endif
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/debug arbiter for the single-ported data memory; one access in flight at a time.
// Tie-break is round-robin when DMEM_ARB_RR_EN is defined, otherwise the core wins ties.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [31:0]       core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t              state, state_d;
    logic                owner_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                winner;
    logic                arb;

    // Byte offset and bits above the memory index are ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{core_addr[31:ADDR_W+2], core_addr[1:0],
                                dbg_addr[31:ADDR_W+2],  dbg_addr[1:0]};

    assign arb = ((state == IDLE) || (state == RESP)) && (core_req || dbg_req);

`ifdef DMEM_ARB_RR_EN
    logic last_winner;

    rr_pick2 u_pick (
        .req         ({dbg_req, core_req}),
        .last_winner (last_winner),
        .winner      (winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_winner <= PORT_DBG;
        end else if (arb) begin
            last_winner <= winner;
        end
    end
`else
    rr_pick2 u_pick (
        .req    ({dbg_req, core_req}),
        .winner (winner)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            owner_q <= PORT_CORE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_d;
            if (arb) begin
                owner_q <= winner;
                if (winner == PORT_DBG) begin
                    we_q    <= dbg_we;
                    addr_q  <= dbg_addr[ADDR_W+1:2];
                    wdata_q <= dbg_wdata;
                end else begin
                    we_q    <= core_we;
                    addr_q  <= core_addr[ADDR_W+1:2];
                    wdata_q <= core_wdata;
                end
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (arb) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = arb ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        core_gnt    = 1'b0;
        dbg_gnt     = 1'b0;
        core_rvalid = 1'b0;
        dbg_rvalid  = 1'b0;
        core_rdata  = '0;
        dbg_rdata   = '0;
        busy        = (state != IDLE);
        if (state == ACCESS) begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            core_gnt  = (owner_q == PORT_CORE);
            dbg_gnt   = (owner_q == PORT_DBG);
        end else if (state == RESP) begin
            if (owner_q == PORT_CORE) begin
                core_rvalid = 1'b1;
                core_rdata  = we_q ? '0 : mem_rdata;
            end else begin
                dbg_rvalid = 1'b1;
                dbg_rdata  = we_q ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous 128-word memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [31:0] core_addr = '0, core_wdata = '0;
    logic        core_gnt, core_rvalid;
    logic [31:0] core_rdata;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_en, mem_we;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        busy;

    logic        preload = 1'b1;
    logic [31:0] mem [128];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'(i);
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    dmem_arbiter #(.DATA_W(32), .ADDR_W(7)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [6:0]  exp_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_single(input string tag, input logic port, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [6:0] exp_addr, input logic [31:0] exp_rdata);
        if (port == 1'b0) begin
            core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
        end else begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end
        tick();
        check({tag, "_gnt"}, {30'd0, dbg_gnt, core_gnt}, port ? 32'd2 : 32'd1);
        check({tag, "_mem_en"}, {31'd0, mem_en}, 32'd1);
        check({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, we});
        check({tag, "_mem_addr"}, {25'd0, mem_addr}, {25'd0, exp_addr});
        if (we) check({tag, "_mem_wdata"}, mem_wdata, wdata);
        core_req = 1'b0;
        dbg_req  = 1'b0;
        tick();
        check({tag, "_rvalid"}, {30'd0, dbg_rvalid, core_rvalid}, port ? 32'd2 : 32'd1);
        check({tag, "_rdata"}, port ? dbg_rdata : core_rdata, exp_rdata);
        check({tag, "_other_rdata"}, port ? core_rdata : dbg_rdata, 32'd0);
        check({tag, "_resp_mem_en"}, {31'd0, mem_en}, 32'd0);
        tick();
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    vec_t vecs [7];
    logic exp_w [5];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0,         7'd5,   32'd5};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'hE3B39000, 7'd16,  32'd0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         7'd16,  32'hE3B39000};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0204, 32'h0,         7'd1,   32'd1};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0008, 32'h0000A5A5, 7'd2,   32'd0};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_000B, 32'h0,         7'd2,   32'h0000A5A5};
        vecs[6] = '{1'b1, 1'b0, 32'hFFFF_F1FC, 32'h0,         7'd127, 32'd127};

        tick();
        tick();
        preload = 1'b0;
        check("reset_ctrl", {25'd0, core_gnt, core_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we, busy}, 32'd0);
        check("reset_mem_addr", {25'd0, mem_addr}, 32'd0);
        check("reset_rdata", core_rdata | dbg_rdata | mem_wdata, 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            do_single($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr,
                      vecs[i].wdata, vecs[i].exp_addr, vecs[i].exp_rdata);
        end

        // Back-to-back: core keeps req high and moves to the next address after each grant.
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0C;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check($sformatf("b2b_c%0d_gnt", c), {31'd0, core_gnt}, {31'd0, c % 2 == 1});
            check($sformatf("b2b_c%0d_rvalid", c), {31'd0, core_rvalid}, {31'd0, c % 2 == 0});
            check($sformatf("b2b_c%0d_busy", c), {31'd0, busy}, 32'd1);
            if (c == 1) check("b2b_addr0", {25'd0, mem_addr}, 32'd3);
            if (c == 3) check("b2b_addr1", {25'd0, mem_addr}, 32'd4);
            if (c == 5) check("b2b_addr2", {25'd0, mem_addr}, 32'd6);
            if (c == 2) check("b2b_rdata0", core_rdata, 32'd3);
            if (c == 4) check("b2b_rdata1", core_rdata, 32'd4);
            if (c == 6) check("b2b_rdata2", core_rdata, 32'd6);
            if (c == 1) core_addr = 32'h10;
            if (c == 3) core_addr = 32'h18;
            if (c == 5) core_req = 1'b0;
        end
        tick();
        check("b2b_idle", {31'd0, busy}, 32'd0);

        // Reset during the ACCESS cycle of a write must kill it before the memory edge.
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h30; core_wdata = 32'hDEADBEEF;
        tick();
        check("rst_mid_access_en", {31'd0, mem_en}, 32'd1);
        #2;
        rst = 1'b0;
        core_req = 1'b0;
        #1;
        check("rst_mid_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mid_outs", {28'd0, core_gnt, core_rvalid, mem_we, busy}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_mid_no_rvalid", {31'd0, core_rvalid}, 32'd0);
        rst = 1'b1;
        tick();
        check("rst_mid_idle", {31'd0, busy}, 32'd0);
        check("rst_mid_no_rvalid2", {31'd0, core_rvalid}, 32'd0);
        do_single("rst_readback", 1'b0, 1'b0, 32'h30, 32'h0, 7'd12, 32'd12);

        // Tie-break sequence from a fresh reset (last_winner = DBG).
        reset_pulse();
`ifdef DMEM_ARB_RR_EN
        exp_w = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h04;
        dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_addr  = 32'h1C;
        for (int c = 1; c <= 10; c++) begin
            tick();
            check($sformatf("tie_c%0d_busy", c), {31'd0, busy}, 32'd1);
            if (c % 2 == 1) begin
                check($sformatf("tie_c%0d_gnt", c), {30'd0, dbg_gnt, core_gnt},
                      exp_w[(c-1)/2] ? 32'd2 : 32'd1);
                if (c == 7) begin
                    if (exp_w[3]) dbg_req = 1'b0;
                    else core_req = 1'b0;
                end
                if (c == 9) begin
                    core_req = 1'b0;
                    dbg_req  = 1'b0;
                end
            end else begin
                check($sformatf("tie_c%0d_rvalid", c), {30'd0, dbg_rvalid, core_rvalid},
                      exp_w[c/2-1] ? 32'd2 : 32'd1);
                check($sformatf("tie_c%0d_rdata", c), exp_w[c/2-1] ? dbg_rdata : core_rdata,
                      exp_w[c/2-1] ? 32'd7 : 32'd1);
            end
        end
        tick();
        check("tie_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
